wm8960_cfg_sequencer: RTL and testbench
=======================================

WM8960_CFG_SEQUENCER -- requirements
Module: wm8960_cfg_sequencer

Interface
REQ-001 The block SHALL have parameter RST_WAIT, default 50000, meaning the idle cycles after the table-index-0 (soft reset) write (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, meaning the retries per register after a NACK before the block aborts.
REQ-003 The block SHALL have parameter VOL_IDX, default 18, meaning the first of the two volume table entries (VOL_IDX, VOL_IDX+1).
REQ-004 The block SHALL have port clk  in  1  system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port start  in  1  single-cycle pulse that requests a full init pass.
REQ-007 The block SHALL have port vol_update  in  1  single-cycle pulse that requests a rewrite of the volume entries only.
REQ-008 The block SHALL have port tbl_addr  out  8  init-table index.
REQ-009 The block SHALL have port tbl_q  in  16  table word, registered: valid 1 cycle after tbl_addr.
REQ-010 The block SHALL have port dev_id  in  8  I2C device address from the table.
REQ-011 The block SHALL have port lut_size  in  8  number of table entries.
REQ-012 The block SHALL have port i2c_req  out  1  write request to the I2C master, level.
REQ-013 The block SHALL have port i2c_dev  out  8  device address, driven with i2c_req.
REQ-014 The block SHALL have port i2c_wdata  out  16  {reg[6:0], data[8:0]}, driven with i2c_req.
REQ-015 The block SHALL have port i2c_done  in  1  single-cycle pulse marking the end of a transfer.
REQ-016 The block SHALL have port i2c_ack_err  in  1  NACK flag, sampled only in the cycle i2c_done is high.
REQ-017 The block SHALL have port busy  out  1  high while the block is in any state other than IDLE, DONE or ERR.
REQ-018 The block SHALL have port init_done  out  1  high after a full pass completes without an unrecoverable NACK.
REQ-019 The block SHALL have port init_err  out  1  high after a transfer is aborted once retries are exhausted.

Function
REQ-020 The FSM states SHALL be IDLE, FETCH, LATCH, REQ, WAIT, RSTW, DONE and ERR.
REQ-021 After reset release, the block SHALL enter FETCH with idx=0 on the first clock; this is an implicit start.
REQ-022 In FETCH, tbl_addr SHALL equal idx. The block SHALL then go to LATCH and capture tbl_q into a local register one cycle later. This accounts for the 1-cycle table latency.
REQ-023 On entering REQ, the block SHALL assert i2c_req with stable i2c_dev and i2c_wdata, and hold them until i2c_done.
REQ-024 i2c_req SHALL drop in the cycle after i2c_done. The block SHALL never issue back-to-back requests without passing through FETCH.
REQ-025 On i2c_done with i2c_ack_err=0 and idx=0 of a full pass, the block SHALL go to RSTW. It SHALL count RST_WAIT cycles there, then advance.
REQ-026 On i2c_done with i2c_ack_err=0 in any other case, the block SHALL advance to the next idx.
REQ-027 On i2c_done with i2c_ack_err=1 and retry<MAX_RETRY, the block SHALL increment retry and re-enter REQ with the same data. It SHALL NOT refetch the table.
REQ-028 On a NACK with retry=MAX_RETRY, the block SHALL go to ERR and set init_err=1. init_done SHALL stay 0.
REQ-029 Advance rule: if idx+1 = end, go to DONE with init_done=1. Otherwise go to FETCH with idx+1 and retry=0.
REQ-030 For a full pass, end SHALL be lut_size. For a volume pass, end SHALL be VOL_IDX+2.
REQ-031 A start pulse in IDLE, DONE or ERR SHALL begin a full pass: idx=0, init_done=0, init_err=0.
REQ-032 A vol_update pulse in DONE SHALL begin a volume pass at idx=VOL_IDX. init_done SHALL drop for the duration of that pass.
REQ-033 A vol_update pulse in IDLE or ERR SHALL be ignored.
REQ-034 While busy, the block SHALL latch vol_update into a pending flag. On reaching DONE, it SHALL start a volume pass immediately if the flag is set, and clear the flag.
REQ-035 start while busy SHALL be ignored. If start and vol_update arrive in the same cycle, start SHALL win and pending SHALL be cleared.
REQ-036 lut_size=0 SHALL go straight to DONE without issuing any request. lut_size≤VOL_IDX+1 SHALL make vol_update ignored.
REQ-037 idx and retry SHALL be 8 bits and 2 bits (ceil(log2(MAX_RETRY+1))) and SHALL never wrap. The RSTW counter SHALL be 16 bits, saturating.

Reset
REQ-038 While reset_n=0, outputs SHALL be: i2c_req=0, i2c_dev=0, i2c_wdata=0, tbl_addr=0, busy=0, init_done=0, init_err=0. Internal state SHALL be idx=0, retry=0, pending=0, state=IDLE.
REQ-039 A reset asserted mid-transfer SHALL drop i2c_req asynchronously. The block SHALL NOT wait for i2c_done.
REQ-040 After reset release, the block SHALL restart from idx=0 per REQ-021.

Structure
REQ-041 State encoding and the RST_WAIT/MAX_RETRY defaults SHALL live in shared package wm8960_pkg, alongside the WM8960 register-index constants.
REQ-042 The block SHALL contain one sub-module, wm8960_wait_cnt, a loadable down-counter with a done flag, used for RSTW.

Verification
REQ-043 Reset release with lut_size=20 and an I2C model that always ACKs -> 20 requests in index order. The first request SHALL be i2c_wdata=16'h1E00. A gap of ≥RST_WAIT cycles SHALL follow request 0. init_done=1 after the 20th i2c_done.
REQ-044 NACK on idx 5 twice, then ACK -> 3 requests carrying identical i2c_wdata. The sequence SHALL continue to init_done=1 with 22 requests in total.
REQ-045 NACK on idx 7 four times -> exactly 4 requests for idx 7, then init_err=1, busy=0, no further requests.
REQ-046 vol_update in DONE -> exactly 2 requests (idx 18, 19). init_done SHALL be low only during the pass.
REQ-047 vol_update during a full pass at idx 10 -> the full pass completes, then 2 volume requests follow, then DONE.
REQ-048 reset_n pulsed low while i2c_req=1 at idx 12 -> i2c_req=0 within the same cycle. After release, the first request SHALL be idx 0 again.

Source files
------------

// File: rtl/wm8960_pkg.sv
// wm8960_pkg: shared FSM states, sequencer defaults and WM8960 register indices
package wm8960_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LATCH, ST_REQ, ST_WAIT, ST_RSTW, ST_DONE, ST_ERR
  } state_t;
  localparam int RST_WAIT_DEF  = 50000;
  localparam int MAX_RETRY_DEF = 3;
  localparam int VOL_IDX_DEF   = 18;
  localparam int CNT_W         = 16;
  localparam logic [6:0] R_LINVOL   = 7'h00;
  localparam logic [6:0] R_RINVOL   = 7'h01;
  localparam logic [6:0] R_LOUT1    = 7'h02;
  localparam logic [6:0] R_ROUT1    = 7'h03;
  localparam logic [6:0] R_CLOCK1   = 7'h04;
  localparam logic [6:0] R_CTRL1    = 7'h05;
  localparam logic [6:0] R_CTRL2    = 7'h06;
  localparam logic [6:0] R_IFACE1   = 7'h07;
  localparam logic [6:0] R_RESET    = 7'h0F;
  localparam logic [6:0] R_PWR1     = 7'h19;
  localparam logic [6:0] R_PWR2     = 7'h1A;
  localparam logic [6:0] R_LOUTMIX  = 7'h22;
  localparam logic [6:0] R_ROUTMIX  = 7'h25;
  localparam logic [6:0] R_PWR3     = 7'h2F;
  function automatic logic [15:0] wm_word(input logic [6:0] r, input logic [8:0] d);
    return {r, d};
  endfunction
endpackage

// File: rtl/wm8960_wait_cnt.sv
// wm8960_wait_cnt: loadable saturating down-counter with a zero flag
module wm8960_wait_cnt
  import wm8960_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_val,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  // load has priority; counting stops at zero instead of wrapping
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_en && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_done = r_cnt == '0;
endmodule

// File: rtl/wm8960_cfg_sequencer.sv
// wm8960_cfg_sequencer: walks the WM8960 init table issuing one I2C write per entry
module wm8960_cfg_sequencer
  import wm8960_pkg::*;
#(
  parameter int RST_WAIT  = RST_WAIT_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int VOL_IDX   = VOL_IDX_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        vol_update,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_q,
  input  logic [7:0]  dev_id,
  input  logic [7:0]  lut_size,
  output logic        i2c_req,
  output logic [7:0]  i2c_dev,
  output logic [15:0] i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  output logic        busy,
  output logic        init_done,
  output logic        init_err
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [CNT_W-1:0] WAIT_VAL =
    (RST_WAIT > (1 << CNT_W) - 1) ? {CNT_W{1'b1}} : CNT_W'(RST_WAIT);
  localparam logic [7:0] VOL_FIRST = 8'(VOL_IDX);
  localparam logic [8:0] VOL_END = 9'(VOL_IDX + 2);
  state_t r_state, w_next;
  logic [7:0] r_idx, r_dev, w_end;
  logic [RW-1:0] r_retry;
  logic [15:0] r_wdata;
  logic r_pend, r_vol;
  logic w_go_full, w_go_vol, w_adv, w_rty, w_load, w_last, w_vol_ok, w_wdone, w_busy;
  assign w_end    = r_vol ? VOL_END[7:0] : lut_size;
  assign w_last   = ({1'b0, r_idx} + 9'd1) >= {1'b0, w_end};
  assign w_vol_ok = {1'b0, lut_size} >= VOL_END;
  assign w_busy   = !(r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
  assign tbl_addr  = r_idx;
  assign i2c_req   = r_state == ST_REQ || r_state == ST_WAIT;
  assign i2c_dev   = r_dev;
  assign i2c_wdata = r_wdata;
  assign busy      = w_busy;
  assign init_done = r_state == ST_DONE;
  assign init_err  = r_state == ST_ERR;
  wm8960_wait_cnt #(.W(CNT_W)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_en    (r_state == ST_RSTW),
    .i_val   (WAIT_VAL),
    .o_done  (w_wdone)
  );
  // state register; reset drops i2c_req immediately without waiting for the master
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  // next state plus the pass-start, advance, retry and wait-load strobes
  always_comb begin
    w_next    = r_state;
    w_go_full = 1'b0;
    w_go_vol  = 1'b0;
    w_adv     = 1'b0;
    w_rty     = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      ST_IDLE:  w_go_full = 1'b1;
      ST_DONE: begin
        w_go_full = start;
        w_go_vol  = !start && (vol_update || r_pend) && w_vol_ok;
      end
      ST_ERR:   w_go_full = start;
      ST_FETCH: w_next = ST_LATCH;
      ST_LATCH: w_next = ST_REQ;
      ST_REQ, ST_WAIT: begin
        w_next = ST_WAIT;
        if (i2c_done && i2c_ack_err) begin
          w_next = r_retry == RMAX ? ST_ERR : ST_LATCH;
          w_rty  = r_retry != RMAX;
        end else if (i2c_done && r_idx == 8'd0 && !r_vol) begin
          w_next = ST_RSTW;
          w_load = 1'b1;
        end else if (i2c_done) w_adv = 1'b1;
      end
      ST_RSTW:  w_adv = w_wdone;
      default:  w_next = ST_IDLE;
    endcase
    if (w_adv) w_next = w_last ? ST_DONE : ST_FETCH;
    if (w_go_full) w_next = lut_size == 8'd0 ? ST_DONE : ST_FETCH;
    if (w_go_vol) w_next = ST_FETCH;
  end
  // index/retry/pending bookkeeping; table word captured only on the first attempt so retries resend it unchanged
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_idx   <= '0;
      r_retry <= '0;
      r_pend  <= 1'b0;
      r_vol   <= 1'b0;
      r_dev   <= '0;
      r_wdata <= '0;
    end else begin
      if (w_go_full) begin
        r_idx   <= '0;
        r_retry <= '0;
        r_vol   <= 1'b0;
        r_pend  <= 1'b0;
      end else if (w_go_vol) begin
        r_idx   <= VOL_FIRST;
        r_retry <= '0;
        r_vol   <= 1'b1;
        r_pend  <= 1'b0;
      end else begin
        if (r_state == ST_DONE) r_pend <= 1'b0;
        else if (w_busy && vol_update) r_pend <= 1'b1;
        if (w_adv && !w_last) begin
          r_idx   <= r_idx + 8'd1;
          r_retry <= '0;
        end
        if (w_rty) r_retry <= r_retry + 1'b1;
      end
      if (r_state == ST_LATCH && r_retry == '0) begin
        r_dev   <= dev_id;
        r_wdata <= tbl_q;
      end
    end
endmodule

// File: tb/tb_wm8960_cfg_sequencer.sv
// tb_wm8960_cfg_sequencer: directed scenarios against an init-table ROM and I2C responder model
module tb_wm8960_cfg_sequencer;
  import wm8960_pkg::*;
  localparam int RWT = 40;
  localparam int MR  = 3;
  localparam int VI  = 18;
  localparam int LAT = 3;
  localparam logic [7:0] DEV = 8'h34;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, vol_update = 1'b0;
  logic i2c_done = 1'b0, i2c_ack_err = 1'b0;
  logic [7:0] tbl_addr, i2c_dev, dev_id = DEV, lut_size = 8'd20;
  logic [15:0] tbl_q = '0, i2c_wdata;
  logic i2c_req, busy, init_done, init_err;
  logic [15:0] rom [0:255];
  int n_chk = 0, n_fail = 0, n_req = 0, cyc = 0, t_done = 0, lat = 0, nack_left = 0;
  int exp_q[$];
  logic [15:0] cur_word = '0, nack_word = '0, first_word = '0;
  bit in_xfer = 0, drop_chk = 0, gap_pend = 0;

  wm8960_cfg_sequencer #(.RST_WAIT(RWT), .MAX_RETRY(MR), .VOL_IDX(VI)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .vol_update(vol_update),
    .tbl_addr(tbl_addr), .tbl_q(tbl_q), .dev_id(dev_id), .lut_size(lut_size),
    .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_wdata(i2c_wdata),
    .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err),
    .busy(busy), .init_done(init_done), .init_err(init_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tbl_q <= rom[tbl_addr];

  initial for (int i = 0; i < 256; i++)
    rom[i] = (i == 0) ? wm_word(R_RESET, 9'd0) : wm_word(7'(i), 9'(i * 13 + 5));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // expected request order for one pass: each index once, a NACKed index repeated per retry, abort after MR retries
  task automatic plan(input int first, input int last, input int nidx, input int nn);
    exp_q.delete();
    n_req = 0;
    gap_pend = 0;
    nack_word = rom[nidx];
    nack_left = nn;
    for (int i = first; i < last; i++) begin
      int tries;
      tries = (i == nidx) ? ((nn > MR) ? MR + 1 : nn + 1) : 1;
      repeat (tries) exp_q.push_back(i);
      if (i == nidx && nn > MR) break;
    end
  endtask

  task automatic pulse(input bit s, input bit v);
    @(posedge clk); #2;
    start = s;
    vol_update = v;
    @(posedge clk); #2;
    start = 1'b0;
    vol_update = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (n < 3000 && (exp_q.size() != 0 || busy || in_xfer));
    if (n >= 3000) fail_now(nm);
  endtask

  task automatic wait_word(input int idx, input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (n < 2000 && !(i2c_req && i2c_wdata == rom[idx]));
    if (n >= 2000) fail_now(nm);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_req"}, i2c_req, 0);
    chk({nm, "_dev"}, i2c_dev, 0);
    chk({nm, "_wdata"}, i2c_wdata, 0);
    chk({nm, "_addr"}, tbl_addr, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, init_done, 0);
    chk({nm, "_err"}, init_err, 0);
  endtask

  // I2C responder plus per-cycle scoreboard: request order, stable payload, req drop after done, reset gap
  initial forever begin
    @(negedge clk);
    cyc++;
    i2c_done = 1'b0;
    i2c_ack_err = 1'b0;
    if (!reset_n) begin
      in_xfer = 0;
      drop_chk = 0;
      gap_pend = 0;
    end else begin
      chk("flags_exclusive", int'(busy) + int'(init_done) + int'(init_err) <= 1, 1);
      if (drop_chk) begin
        chk("req_drop_after_done", i2c_req, 0);
        drop_chk = 0;
      end else if (i2c_req && !in_xfer) begin
        n_req++;
        if (n_req == 1) first_word = i2c_wdata;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_req: got wdata 0x%h, expected no request", i2c_wdata);
          cur_word = i2c_wdata;
        end else begin
          cur_word = rom[exp_q.pop_front()];
          chk("req_wdata", i2c_wdata, cur_word);
          chk("req_dev", i2c_dev, DEV);
        end
        if (gap_pend) begin
          chk("rst_gap", (cyc - t_done) >= RWT, 1);
          gap_pend = 0;
        end
        in_xfer = 1;
        lat = 0;
      end else if (i2c_req) begin
        chk("wdata_stable", i2c_wdata, cur_word);
        chk("dev_stable", i2c_dev, DEV);
        lat++;
        if (lat == LAT) begin
          i2c_done = 1'b1;
          i2c_ack_err = cur_word == nack_word && nack_left > 0;
          if (i2c_ack_err) nack_left--;
          else if (cur_word == rom[0]) begin
            gap_pend = 1;
            t_done = cyc;
          end
          in_xfer = 0;
          drop_chk = 1;
        end
      end else if (in_xfer) begin
        chk("req_held_until_done", i2c_req, 1);
        in_xfer = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    plan(0, 20, 255, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("boot_busy", busy, 1);
    chk("boot_tbl_addr", tbl_addr, 0);
    wait_end("boot_pass");
    chk("boot_done", init_done, 1);
    chk("boot_err", init_err, 0);
    chk("boot_nreq", n_req, 20);
    chk("boot_first_word", first_word, 16'h1E00);
    plan(0, 20, 5, 2);
    pulse(1, 0);
    @(negedge clk);
    chk("start_clears_done", init_done, 0);
    wait_end("nack5_pass");
    chk("nack5_done", init_done, 1);
    chk("nack5_nreq", n_req, 22);
    plan(0, 20, 7, 4);
    pulse(1, 0);
    wait_end("nack7_pass");
    chk("nack7_err", init_err, 1);
    chk("nack7_done", init_done, 0);
    chk("nack7_busy", busy, 0);
    chk("nack7_nreq", n_req, 11);
    repeat (30) @(negedge clk);
    chk("nack7_no_more", n_req, 11);
    plan(0, 0, 255, 0);
    pulse(0, 1);
    repeat (20) @(negedge clk);
    chk("vol_in_err_nreq", n_req, 0);
    chk("vol_in_err_err", init_err, 1);
    chk("vol_in_err_busy", busy, 0);
    plan(0, 20, 255, 0);
    pulse(1, 0);
    wait_end("clean_pass");
    chk("clean_done", init_done, 1);
    chk("clean_err", init_err, 0);
    plan(18, 20, 255, 0);
    pulse(0, 1);
    @(negedge clk);
    chk("vol_done_low", init_done, 0);
    chk("vol_busy", busy, 1);
    wait_end("vol_pass");
    chk("vol_done", init_done, 1);
    chk("vol_nreq", n_req, 2);
    plan(0, 20, 255, 0);
    exp_q.push_back(18);
    exp_q.push_back(19);
    pulse(1, 0);
    wait_word(10, "wait_idx10");
    pulse(0, 1);
    wait_end("pend_pass");
    chk("pend_done", init_done, 1);
    chk("pend_nreq", n_req, 22);
    plan(0, 20, 255, 0);
    pulse(1, 1);
    wait_end("both_pass");
    repeat (20) @(negedge clk);
    chk("both_nreq", n_req, 20);
    chk("both_done", init_done, 1);
    plan(0, 20, 255, 0);
    pulse(1, 0);
    wait_word(12, "wait_idx12");
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("async_req_drop", i2c_req, 0);
    chk("async_busy_drop", busy, 0);
    plan(0, 20, 255, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("midreset");
    @(posedge clk); #2 reset_n = 1'b1;
    wait_end("rerun_pass");
    chk("rerun_done", init_done, 1);
    chk("rerun_nreq", n_req, 20);
    chk("rerun_first_word", first_word, 16'h1E00);
    lut_size = 8'd1;
    plan(0, 1, 255, 0);
    pulse(1, 0);
    wait_end("lut1_pass");
    chk("lut1_done", init_done, 1);
    chk("lut1_nreq", n_req, 1);
    lut_size = 8'd0;
    plan(0, 0, 255, 0);
    pulse(1, 0);
    @(negedge clk);
    chk("lut0_done", init_done, 1);
    chk("lut0_busy", busy, 0);
    pulse(0, 1);
    repeat (10) @(negedge clk);
    chk("lut0_vol_nreq", n_req, 0);
    chk("lut0_vol_done", init_done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
